// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : bytes packed into one instruction word
//   WORD_W         : instruction word width
package inst_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

endpackage

// File: rtl/inst_ram.sv
// DEPTH x WORD_W instruction store.
//   clk, resetn : clock, async active-low reset (clears every word to a nop)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : asynchronous read port; out-of-range addresses read 0
module inst_ram
    import inst_loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (we && waddr == AW'(i)) mem[i] <= wdata;
        end
    end

    // Addresses past DEPTH return a nop rather than aliasing a real word.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) rdata = mem[raddr];
    end

endmodule

// File: rtl/inst_ram_loader.sv
// Reprogrammable instruction memory with a byte-stream loader.
//   clk, resetn            : clock, async active-low reset
//   load_start, load_len   : begin a load of load_len words (clamped to DEPTH)
//   load_abort             : stop an active load, keeping words already written
//   byte_valid/byte_data/byte_ready : byte stream, big-endian within each word
//   load_busy, load_done, load_err  : status; done/err are one-cycle pulses
//   words_loaded           : words written by the current or last load
//   fetch_addr, fetch_inst : CPU fetch port, combinational
module inst_ram_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_start,
    input  logic [AW:0]       load_len,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [AW:0]       words_loaded,
    input  logic [AW-1:0]     fetch_addr,
    output logic [WORD_W-1:0] fetch_inst
);

    localparam int          BCW     = $clog2(BYTES_PER_WORD);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t            state;
    logic [AW:0]       len;
    logic [AW-1:0]     wr_ptr;
    logic [BCW-1:0]    byte_cnt;
    logic [WORD_W-9:0] asm_q;   // leading bytes of the word being assembled

    logic              accept;
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic [AW:0]       wl_next;
    logic [AW:0]       len_clamp;

    // Abort wins over a byte presented in the same cycle.
    always_comb begin
        accept    = (state == RECV) && byte_valid && !load_abort;
        we        = accept && (byte_cnt == BCW'(BYTES_PER_WORD - 1));
        wdata     = {asm_q, byte_data};
        wl_next   = words_loaded + ONE_W;
        len_clamp = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    end

    assign byte_ready = (state == RECV);
    assign load_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            len          <= '0;
            wr_ptr       <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    len          <= len_clamp;
                    wr_ptr       <= '0;
                    byte_cnt     <= '0;
                    words_loaded <= '0;
                    if (len_clamp == '0) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end
                RECV: if (load_abort) begin
                    state    <= IDLE;
                    load_err <= 1'b1;
                    byte_cnt <= '0;
                end else if (accept) begin
                    byte_cnt <= byte_cnt + BCW'(1);
                    asm_q    <= {asm_q[WORD_W-17:0], byte_data};
                    if (we) begin
                        wr_ptr       <= wr_ptr + AW'(1);
                        words_loaded <= wl_next;
                        if (wl_next == len) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    inst_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (we),
        .waddr  (wr_ptr),
        .wdata  (wdata),
        .raddr  (fetch_addr),
        .rdata  (fetch_inst)
    );

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader (DEPTH=32, AW=5).
module tb_inst_ram_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          load_abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_inst;

    int errors = 0;
    int checks = 0;

    inst_ram_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_abort   (load_abort),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .fetch_addr   (fetch_addr),
        .fetch_inst   (fetch_inst)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input int a, input logic [31:0] exp);
        fetch_addr = AW'(a);
        #1;
        chk(tag, fetch_inst, exp);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic start(input int n);
        load_start = 1'b1;
        load_len   = (AW+1)'(n);
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    logic [7:0] s2 [8] = '{8'h24, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h11, 8'h00};
    logic [7:0] sa [6] = '{8'hAC, 8'h25, 8'h00, 8'h13, 8'h00, 8'hA2};

    initial begin
        resetn = 1'b0; load_start = 1'b0; load_len = '0; load_abort = 1'b0;
        byte_valid = 1'b0; byte_data = '0; fetch_addr = '0;

        // Reset state
        step(); step();
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_busy",  32'(load_busy), 0);
        chk("rst_done",  32'(load_done), 0);
        chk("rst_err",   32'(load_err), 0);
        chk("rst_wl",    32'(words_loaded), 0);
        rd("rst_mem0", 0, 32'h0);
        rd("rst_mem31", 31, 32'h0);
        resetn = 1'b1;
        step();

        // Two-word load, back-to-back bytes
        start(2);
        chk("t2_busy",  32'(load_busy), 1);
        chk("t2_ready", 32'(byte_ready), 1);
        for (int i = 0; i < 8; i++) begin
            send(s2[i]);
            if (i == 6) chk("t2_done_early", 32'(load_done), 0);
        end
        chk("t2_done",    32'(load_done), 1);
        chk("t2_ready_d", 32'(byte_ready), 0);
        chk("t2_wl",      32'(words_loaded), 2);
        step();
        chk("t2_done_off", 32'(load_done), 0);
        chk("t2_idle",     32'(load_busy), 0);
        rd("t2_mem0", 0, 32'h24010001);
        rd("t2_mem1", 1, 32'h00011100);
        rd("t2_mem2", 2, 32'h0);

        // Gapped valid: 3 idle cycles between bytes 2 and 3
        do_reset();
        start(2);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                byte_data = 8'hFF;
                step(); step(); step();
            end
            send(s2[i]);
        end
        chk("gap_done", 32'(load_done), 1);
        rd("gap_mem0", 0, 32'h24010001);
        rd("gap_mem1", 1, 32'h00011100);
        step();

        // Abort mid-word; the byte alongside the abort must be dropped
        do_reset();
        start(3);
        for (int i = 0; i < 6; i++) send(sa[i]);
        chk("ab_wl_pre", 32'(words_loaded), 1);
        load_abort = 1'b1; byte_valid = 1'b1; byte_data = 8'h77;
        step();
        load_abort = 1'b0; byte_valid = 1'b0;
        chk("ab_err",  32'(load_err), 1);
        chk("ab_busy", 32'(load_busy), 0);
        chk("ab_wl",   32'(words_loaded), 1);
        rd("ab_mem0", 0, 32'hAC250013);
        rd("ab_mem1", 1, 32'h0);
        step();
        chk("ab_err_off", 32'(load_err), 0);

        // Next load accepted; read-during-write on word 0
        start(1);
        chk("rs_busy", 32'(load_busy), 1);
        chk("rs_wl0",  32'(words_loaded), 0);
        send(8'h08); send(8'h00); send(8'h00);
        fetch_addr = '0;
        byte_valid = 1'b1; byte_data = 8'h00;
        #1;
        chk("rw_before", fetch_inst, 32'hAC250013);
        step();
        byte_valid = 1'b0;
        chk("rw_after", fetch_inst, 32'h08000000);
        chk("rw_done",  32'(load_done), 1);
        step();

        // len = 0: immediate done, never ready
        start(0);
        chk("z_done",  32'(load_done), 1);
        chk("z_ready", 32'(byte_ready), 0);
        chk("z_busy",  32'(load_busy), 1);
        step();
        chk("z_done_off", 32'(load_done), 0);
        chk("z_ready2",   32'(byte_ready), 0);
        chk("z_idle",     32'(load_busy), 0);

        // len = 40 clamps to 32 words; bytes are 0..127
        start(40);
        for (int i = 0; i < 128; i++) begin
            send(8'(i));
            if (i == 126) chk("big_done_early", 32'(load_done), 0);
        end
        chk("big_done", 32'(load_done), 1);
        chk("big_wl",   32'(words_loaded), 32);
        rd("big_mem0",  0, 32'h00010203);
        rd("big_mem31", 31, 32'h7C7D7E7F);
        step();
        chk("big_idle", 32'(load_busy), 0);

        // Reset mid-load after 5 bytes
        start(2);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h11);
        rd("mr_mem0_pre", 0, 32'hDEADBEEF);
        resetn = 1'b0;
        #1;
        chk("mr_busy",  32'(load_busy), 0);
        chk("mr_ready", 32'(byte_ready), 0);
        chk("mr_done",  32'(load_done), 0);
        chk("mr_err",   32'(load_err), 0);
        chk("mr_wl",    32'(words_loaded), 0);
        rd("mr_mem0", 0, 32'h0);
        rd("mr_mem31", 31, 32'h0);
        step();
        resetn = 1'b1;
        step();
        start(1);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        chk("mr2_done", 32'(load_done), 1);
        chk("mr2_wl",   32'(words_loaded), 1);
        rd("mr2_mem0", 0, 32'h12345678);
        rd("mr2_mem1", 1, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
